// File: rtl/rv_fifo_pkg.sv
// Shared defaults for the ready/valid FIFO slice.
package rv_fifo_pkg;

    localparam int RV_FIFO_DATA_WIDTH = 32;
    localparam int RV_FIFO_ADDR_WIDTH = 4;

endpackage

// File: rtl/rv_memory_double_port.sv
// Two-port synchronous RAM: both ports may write; port 1 also has a
// registered read output that holds its value when no read is issued.
module rv_memory_double_port
    import rv_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = RV_FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = RV_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  enable0,
    input  logic                  write_enable0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic                  enable1,
    input  logic                  write_enable1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data_in1,
    output logic [DATA_WIDTH-1:0] data_out1
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Storage writes from either port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (enable0 && write_enable0) mem[addr0] <= data_in0;
        if (enable1 && write_enable1) mem[addr1] <= data_in1;
    end

    // Port 1 read register; holds when no read is issued.
    always_ff @(posedge clk) begin
        if (enable1 && !write_enable1) data_out1 <= mem[addr1];
    end

endmodule

// File: rtl/rv_fifo.sv
// Ready/valid FIFO on a registered-output RAM. The RAM read register acts
// as an extra output stage, so capacity is DEPTH+1 words.
module rv_fifo
    import rv_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = RV_FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = RV_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      mem_count;
    logic                  push;
    logic                  rd_issue;
    logic                  pop;

    // Handshakes and read scheduling. in_ready depends on registered state
    // only; push/read are masked in a reset cycle so they leave no trace.
    always_comb begin
        in_ready = (mem_count < CNT_W'(DEPTH));
        push     = in_valid && in_ready && !rst;
        pop      = out_valid && out_ready;
        rd_issue = (mem_count != '0) && (!out_valid || out_ready) && !rst;
        count    = mem_count + CNT_W'(out_valid);
    end

    // Pointers, memory occupancy and output-stage valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
            if (push && !rd_issue)      mem_count <= mem_count + 1'b1;
            else if (!push && rd_issue) mem_count <= mem_count - 1'b1;
            if (rd_issue) out_valid <= 1'b1;
            else if (pop) out_valid <= 1'b0;
        end
    end

    rv_memory_double_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk          (clk),
        .enable0      (push),
        .write_enable0(push),
        .addr0        (wr_ptr),
        .data_in0     (in_data),
        .enable1      (rd_issue),
        .write_enable1(1'b0),
        .addr1        (rd_ptr),
        .data_in1     ('0),
        .data_out1    (out_data)
    );

endmodule

// File: tb/tb_rv_fifo.sv
// Directed and random checks of rv_fifo with DEPTH=4 (capacity 5).
module tb_rv_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    rv_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step(); step();
        rst = 1'b0;
        tests++;
        if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA5;
        step();                       // edge E: push
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || count !== 3'd1) begin
            fails++; $display("FAIL single_after_push: got ov=%0b cnt=%0d want ov=0 cnt=1", out_valid, count);
        end
        step();                       // edge E+1: read
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5 || count !== 3'd1) begin
            fails++; $display("FAIL single_out: got ov=%0b data=%0h cnt=%0d want ov=1 data=a5 cnt=1", out_valid, out_data, count);
        end
        out_ready = 1'b1;
        step();                       // pop
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            fails++; $display("FAIL single_pop: got ov=%0b cnt=%0d want ov=0 cnt=0", out_valid, count);
        end
    endtask

    task automatic test_fill();
        do_reset();
        in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = i;
            step();
        end
        tests++;
        if (count !== 3'd5 || in_ready !== 1'b0) begin
            fails++; $display("FAIL fill_full: got cnt=%0d rdy=%0b want cnt=5 rdy=0", count, in_ready);
        end
        in_data = 32'h6;
        step(); step();
        tests++;
        if (count !== 3'd5 || in_ready !== 1'b0 || out_data !== 32'h1) begin
            fails++; $display("FAIL fill_hold6: got cnt=%0d rdy=%0b data=%0h want cnt=5 rdy=0 data=1", count, in_ready, out_data);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== k) begin
                fails++; $display("FAIL fill_drain: got ov=%0b data=%0h want ov=1 data=%0h", out_valid, out_data, k);
            end
            step();
        end
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            fails++; $display("FAIL fill_empty: got ov=%0b cnt=%0d want ov=0 cnt=0", out_valid, count);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        int popped;
        bit seen;
        do_reset();
        exp = 32'h100; popped = 0; seen = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (seen && out_valid !== 1'b1) begin
                tests++; fails++; $display("FAIL stream_bubble: got ov=%0b want 1 at cycle %0d", out_valid, i);
            end
            if (out_valid) begin
                seen = 1;
                tests++;
                if (out_data !== exp) begin fails++; $display("FAIL stream_data: got %0h want %0h", out_data, exp); end
                exp++; popped++;
            end
            in_data = 32'h100 + i;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                tests++;
                if (out_data !== exp) begin fails++; $display("FAIL stream_tail: got %0h want %0h", out_data, exp); end
                exp++; popped++;
            end
            step();
        end
        out_ready = 1'b0;
        tests++;
        if (popped != 20 || count !== 3'd0) begin
            fails++; $display("FAIL stream_total: got popped=%0d cnt=%0d want popped=20 cnt=0", popped, count);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp;
        logic [31:0] held;
        bit stalled;
        bit pat [10] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h200 + i;
            step();
        end
        in_valid = 1'b0;
        exp = 32'h200; stalled = 0; held = '0;
        for (int i = 0; i < 10; i++) begin
            out_ready = pat[i];
            if (stalled) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    fails++; $display("FAIL bp_stable: got ov=%0b data=%0h want ov=1 data=%0h", out_valid, out_data, held);
                end
            end
            stalled = 0;
            if (out_valid) begin
                tests++;
                if (out_data !== exp) begin fails++; $display("FAIL bp_data: got %0h want %0h", out_data, exp); end
                if (out_ready) exp++;
                else begin stalled = 1; held = exp; end
            end
            step();
        end
        out_ready = 1'b0;
        tests++;
        if (exp !== 32'h204 || out_valid !== 1'b0 || count !== 3'd0) begin
            fails++; $display("FAIL bp_total: got next=%0h ov=%0b cnt=%0d want next=204 ov=0 cnt=0", exp, out_valid, count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h300 + i;
            step();
        end
        tests++;
        if (count !== 3'd3) begin fails++; $display("FAIL rstmid_pre: got cnt=%0d want 3", count); end
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid_state: got cnt=%0d ov=%0b rdy=%0b want cnt=0 ov=0 rdy=1", count, out_valid, in_ready);
        end
        in_valid = 1'b1; in_data = 32'h77;
        step();
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h77 || count !== 3'd1) begin
            fails++; $display("FAIL rstmid_first: got ov=%0b data=%0h cnt=%0d want ov=1 data=77 cnt=1", out_valid, out_data, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            fails++; $display("FAIL rstmid_empty: got ov=%0b cnt=%0d want ov=0 cnt=0", out_valid, count);
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp;
        int rfails;
        do_reset();
        rfails = 0;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            #1;
            tests++;
            if (in_ready !== (q.size() < 5)) begin
                fails++; rfails++;
                if (rfails < 10) $display("FAIL rand_ready: got %0b want %0b size=%0d", in_ready, (q.size() < 5), q.size());
            end
            if (out_valid && out_ready) begin
                exp = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
                tests++;
                if (out_data !== exp) begin
                    fails++; rfails++;
                    if (rfails < 10) $display("FAIL rand_data: got %0h want %0h", out_data, exp);
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
            step();
            tests++;
            if (count !== 3'(q.size()) || count > 3'd5) begin
                fails++; rfails++;
                if (rfails < 10) $display("FAIL rand_count: got %0d want %0d", count, q.size());
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
